// File: rtl/uart_echo_pdm.sv
// uart_echo_pdm: 8N1 UART receiver, increment-echo transmitter with a
// one-entry pending slot, 16-bit first-order sigma-delta PDM DAC, and a
// combinational adder on the spare output pins.
module uart_echo_pdm #(
  parameter int unsigned FREQUENCY = 50_000_000,
  parameter int unsigned BPS       = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned DIV  = FREQUENCY / BPS;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = $clog2(DIV + 1);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT_HIGH} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

  // RX side
  logic          rx_s1, rx_s2, rx_d;
  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_valid;

  // Echo glue
  logic          tx_we;
  logic [7:0]    tx_data;
  logic          pend_valid;
  logic [7:0]    pend_data;
  logic [15:0]   pdm_level;

  // TX side
  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_line;
  logic          tx_busy;

  // PDM
  logic [15:0]   pdm_acc;
  logic          pdm_q;

  // Adder
  logic [7:0]    sum_c;
  logic          unused_ok;

  // Two-flop synchronizer on the RX pin plus one delay flop for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= ui_in[0];
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // RX frame FSM: start re-check at half bit, then sample each bit mid-period
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state <= R_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (rx_state)
        R_IDLE: begin
          if (rx_d && !rx_s2) begin
            rx_state <= R_START;
            rx_cnt   <= '0;
          end
        end
        R_START: begin
          if (rx_cnt == CW'(HALF - 1)) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? R_IDLE : R_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        R_DATA: begin
          if (rx_cnt == CW'(DIV - 1)) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= R_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        R_STOP: begin
          if (rx_cnt == CW'(DIV - 1)) begin
            rx_cnt <= '0;
            if (rx_s2) begin
              rx_valid <= 1'b1;
              rx_state <= R_IDLE;
            end else begin
              rx_state <= R_WAIT_HIGH;
            end
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        R_WAIT_HIGH: begin
          if (rx_s2) rx_state <= R_IDLE;
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  always_comb tx_busy = (tx_state != T_IDLE);

  // Echo glue: issue b+1 when TX is free, otherwise park in the pending slot;
  // every valid byte also shifts into the PDM level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_we      <= 1'b0;
      tx_data    <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      pdm_level  <= '0;
    end else begin
      tx_we <= 1'b0;
      if (rx_valid) pdm_level <= {pdm_level[7:0], rx_shift};
      if (!tx_busy && !tx_we && (pend_valid || rx_valid)) begin
        tx_we      <= 1'b1;
        tx_data    <= (pend_valid ? pend_data : rx_shift) + 8'd1;
        pend_valid <= pend_valid && rx_valid;
        if (pend_valid && rx_valid) pend_data <= rx_shift;
      end else if (rx_valid) begin
        pend_valid <= 1'b1;
        pend_data  <= rx_shift;
      end
    end
  end

  // TX frame FSM: start bit, 8 data bits LSB first, stop bit, DIV clocks each
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state <= T_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      case (tx_state)
        T_IDLE: begin
          if (tx_we) begin
            tx_state <= T_START;
            tx_line  <= 1'b0;
            tx_cnt   <= '0;
            tx_shift <= tx_data;
          end
        end
        T_START: begin
          if (tx_cnt == CW'(DIV - 1)) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_line  <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_state <= T_DATA;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        T_DATA: begin
          if (tx_cnt == CW'(DIV - 1)) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_line  <= 1'b1;
              tx_state <= T_STOP;
            end else begin
              tx_line  <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_bit   <= tx_bit + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        T_STOP: begin
          if (tx_cnt == CW'(DIV - 1)) begin
            tx_cnt   <= '0;
            tx_state <= T_IDLE;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        default: tx_state <= T_IDLE;
      endcase
    end
  end

  // First-order sigma-delta: the accumulator carry is the PDM bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pdm_acc <= '0;
      pdm_q   <= 1'b0;
    end else begin
      {pdm_q, pdm_acc} <= {1'b0, pdm_acc} + {1'b0, pdm_level};
    end
  end

  // Output pin mapping; the adder bits are intentionally combinational
  always_comb begin
    sum_c   = ui_in + uio_in;
    uo_out  = {sum_c[5:0], pdm_q, tx_line};
    uio_out = '0;
    uio_oe  = '0;
  end

  assign unused_ok = &{1'b0, ena, sum_c[7:6]};

endmodule

// File: tb/tb_uart_echo_pdm.sv
// Bench for uart_echo_pdm: directed UART frames, TX decoding monitor,
// PDM ones counting and an adder vector table.
module tb_uart_echo_pdm;

  localparam int unsigned FREQ = 1_600_000;
  localparam int unsigned BPS  = 100_000;
  localparam int DIV = int'(FREQ / BPS);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  always #5 clk = ~clk;

  uart_echo_pdm #(.FREQUENCY(FREQ), .BPS(BPS)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0] tx_q[$];
  int         tx_t[$];
  logic [9:0] mon_a, mon_b;
  int         mon_t0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  // TX decoder: samples both ends of every bit, so wrong bit widths show up
  always begin
    @(negedge clk);
    if (rst_n === 1'b1 && uo_out[0] === 1'b0) begin
      mon_t0 = cyc;
      mon_a = '0;
      mon_b = '0;
      mon_a[0] = uo_out[0];
      for (int i = 0; i < 10; i++) begin
        repeat (DIV - 1) @(negedge clk);
        mon_b[i] = uo_out[0];
        if (i < 9) begin
          @(negedge clk);
          mon_a[i+1] = uo_out[0];
        end
      end
      chk("tx_frame_shape", int'(mon_a == mon_b && mon_a[0] == 1'b0 && mon_a[9] == 1'b1), 1);
      tx_q.push_back(mon_a[8:1]);
      tx_t.push_back(mon_t0);
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Drive one frame; expects to be called just after a rising edge
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, output int t_start);
    ui_in[0] = 1'b0;
    t_start  = cyc;
    repeat (DIV) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      ui_in[0] = b[i];
      repeat (DIV) @(posedge clk);
      #1;
    end
    ui_in[0] = stop_ok;
    repeat (DIV) @(posedge clk);
    #1;
    ui_in[0] = 1'b1;
  endtask

  task automatic expect_echo(input string name, input logic [7:0] exp, output int t_tx);
    t_tx = -1;
    for (int i = 0; i < 24 * DIV && tx_q.size() == 0; i++) @(negedge clk);
    if (tx_q.size() == 0) begin
      chk({name, "_timeout"}, 0, 1);
    end else begin
      chk(name, int'(tx_q.pop_front()), int'(exp));
      t_tx = tx_t.pop_front();
    end
  endtask

  task automatic send_echo(input logic [7:0] b, input logic [7:0] exp);
    int t_rx, t_tx;
    align();
    send_frame(b, 1'b1, t_rx);
    expect_echo($sformatf("echo_%02h", b), exp, t_tx);
  endtask

  task automatic count_ones(input int n, output int ones);
    ones = 0;
    repeat (n) begin
      @(negedge clk);
      if (uo_out[1] === 1'b1) ones++;
    end
  endtask

  task automatic no_echo(input string name, input int n);
    repeat (n) @(negedge clk);
    chk(name, tx_q.size(), 0);
  endtask

  typedef struct { logic [7:0] rx; logic [7:0] echo; } echo_vec_t;
  typedef struct { logic [7:0] a; logic [7:0] b; logic [5:0] s; } add_vec_t;

  echo_vec_t ev[4];
  add_vec_t  av[6];

  initial begin
    int t_rx, t_tx, ones;

    ev[0] = '{rx: 8'h41, echo: 8'h42};
    ev[1] = '{rx: 8'hFF, echo: 8'h00};
    ev[2] = '{rx: 8'h00, echo: 8'h01};
    ev[3] = '{rx: 8'h7F, echo: 8'h80};

    av[0] = '{a: 8'h30, b: 8'h15, s: 6'h05};
    av[1] = '{a: 8'hFF, b: 8'h01, s: 6'h00};
    av[2] = '{a: 8'h21, b: 8'h22, s: 6'h03};
    av[3] = '{a: 8'h7F, b: 8'h7F, s: 6'h3E};
    av[4] = '{a: 8'h01, b: 8'h00, s: 6'h01};
    av[5] = '{a: 8'hC3, b: 8'h0D, s: 6'h10};

    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h01;
    uio_in = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_idle", int'(uo_out[0]), 1);
    chk("rst_pdm", int'(uo_out[1]), 0);
    chk("rst_uio_oe", int'(uio_oe), 0);
    chk("rst_uio_out", int'(uio_out), 0);
    rst_n = 1'b1;
    count_ones(10 * DIV, ones);
    chk("idle_pdm_ones", ones, 0);
    chk("idle_no_tx", tx_q.size(), 0);
    chk("idle_line_high", int'(uo_out[0]), 1);

    // Echo table, with start-bit latency measured on the first frame
    for (int i = 0; i < 4; i++) begin
      align();
      send_frame(ev[i].rx, 1'b1, t_rx);
      expect_echo($sformatf("echo_%02h", ev[i].rx), ev[i].echo, t_tx);
      if (i == 0) chk_rng("tx_latency", t_tx - t_rx, 9 * DIV + DIV / 2, 9 * DIV + DIV / 2 + 6);
    end

    // Level 0x8000: exactly half ones over a window that is a multiple of 2
    send_echo(8'h80, 8'h81);
    send_echo(8'h00, 8'h01);
    count_ones(16384, ones);
    chk("pdm_8000", ones, 8192);

    send_echo(8'h00, 8'h01);
    send_echo(8'h00, 8'h01);
    count_ones(4096, ones);
    chk("pdm_0000", ones, 0);

    // Framing error: no echo, level stays zero; next good frame works
    align();
    send_frame(8'h55, 1'b0, t_rx);
    no_echo("framing_no_echo", 14 * DIV);
    count_ones(4096, ones);
    chk("framing_level_kept", ones, 0);
    send_echo(8'h10, 8'h11);

    send_echo(8'hFF, 8'h00);
    send_echo(8'hFF, 8'h00);
    count_ones(4096, ones);
    chk_rng("pdm_ffff", ones, 4095, 4096);

    // Three back-to-back frames exercise the pending slot
    align();
    send_frame(8'h01, 1'b1, t_rx);
    send_frame(8'h02, 1'b1, t_rx);
    send_frame(8'h03, 1'b1, t_rx);
    for (int i = 0; i < 40 * DIV && tx_q.size() < 3; i++) @(negedge clk);
    chk_rng("b2b_count", tx_q.size(), 2, 3);
    if (tx_q.size() > 0) chk("b2b_echo0", int'(tx_q.pop_front()), 8'h02);
    if (tx_q.size() > 0) chk("b2b_echo1", int'(tx_q.pop_front()), 8'h03);
    if (tx_q.size() > 0) chk("b2b_echo2", int'(tx_q.pop_front()), 8'h04);
    tx_t.delete();
    count_ones(4096, ones);
    chk_rng("pdm_0203", ones, 32, 33);

    // One-cycle low glitch while idle must not start a frame
    align();
    ui_in[0] = 1'b0;
    @(posedge clk);
    #1;
    ui_in[0] = 1'b1;
    no_echo("glitch_no_echo", 14 * DIV);

    // Reset in the middle of a frame: nothing delivered, level cleared
    align();
    ui_in[0] = 1'b0;
    repeat (DIV) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      ui_in[0] = (i % 2 == 1);
      repeat (DIV) @(posedge clk);
      #1;
    end
    rst_n    = 1'b0;
    ui_in[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_line_high", int'(uo_out[0]), 1);
    count_ones(256, ones);
    chk("midrst_level_cleared", ones, 0);
    no_echo("midrst_no_echo", 14 * DIV);
    send_echo(8'h20, 8'h21);

    // Adder vectors
    for (int i = 0; i < 6; i++) begin
      ui_in  = av[i].a;
      uio_in = av[i].b;
      #1;
      chk($sformatf("adder_%02h_%02h", av[i].a, av[i].b), int'(uo_out[7:2]), int'(av[i].s));
    end
    ui_in = 8'h01;
    repeat (20 * DIV) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
